seg_scan_ctrl: RTL

//  Time-multiplexes one MyMC14495 hex-to-7-segment decoder across DIGITS common-anode digits.

---
 rtl/seg_scan_ctrl_pkg.sv | 28 ++
 rtl/seg_scan_ctrl_prescaler.sv | 36 +++
 rtl/seg_scan_ctrl.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/seg_scan_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// seg_scan_ctrl_pkg
// Shared definitions for the 7-segment scan controller:
//   - scan_state_e : 1-bit scan FSM state encoding (SCAN_BLANK / SCAN_SHOW)
//   - MAX_DIGITS   : largest supported digit count
//   - AN_OFF       : all-anodes-off pattern, sized for MAX_DIGITS; users take
//                    the low DIGITS bits ({DIGITS{1'b1}})
//   - an_select    : active-low one-hot anode pattern for a digit index
// -----------------------------------------------------------------------------
package seg_scan_ctrl_pkg;

  typedef enum logic {
    SCAN_BLANK = 1'b0,
    SCAN_SHOW  = 1'b1
  } scan_state_e;

  localparam int unsigned MAX_DIGITS = 8;

  localparam logic [MAX_DIGITS-1:0] AN_OFF = {MAX_DIGITS{1'b1}};

  // Active-low anode pattern with only digit 'idx' driven low.
  function automatic logic [MAX_DIGITS-1:0] an_select(input logic [2:0] idx);
    logic [MAX_DIGITS-1:0] one_hot;
    one_hot = {{(MAX_DIGITS-1){1'b0}}, 1'b1} << idx;
    return ~one_hot;
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_prescaler.sv
// -----------------------------------------------------------------------------
// scan_prescaler
// Free-running SCAN_W-bit up counter that defines the scan slot. The slot
// ends on the cycle the counter holds its maximum value; wrap_o flags that
// cycle so the owner can advance on the same edge the counter returns to 0.
// Ports:
//   clk_i    system clock
//   rst_i    synchronous active-high reset (counter -> 0)
//   count_o  current count (position inside the slot)
//   wrap_o   1 while count_o == 2**SCAN_W-1 (last cycle of the slot)
// -----------------------------------------------------------------------------
module scan_prescaler #(
  parameter int unsigned SCAN_W = 17
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic [SCAN_W-1:0] count_o,
  output logic              wrap_o
);

  localparam logic [SCAN_W-1:0] CNT_ONE = SCAN_W'(1);

  logic [SCAN_W-1:0] count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + CNT_ONE;
    end
  end

  assign count_o = count_q;
  assign wrap_o  = (count_q == {SCAN_W{1'b1}});

endmodule

// File: rtl/seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg_scan_ctrl
// Time-multiplexes one hex-to-7-segment decoder across DIGITS common-anode
// digits. A shadow copy of the display word is captured on 'load'; each scan
// slot starts with BLANK_CYC dark cycles (anti-ghosting) and then shows one
// digit. Outputs are registered from next-state values, so they line up with
// the slot position: in the first BLANK cycle of a slot hex/point already
// carry the upcoming digit's data, giving the decoder time to settle.
// Ports:
//   clk        system clock (rising edge)
//   rst        synchronous active-high reset, overrides load
//   load       capture hexs/points/blank into the shadow registers
//   hexs       4*DIGITS nibbles, digit 0 = rightmost = hexs[3:0]
//   points     decimal point request per digit
//   blank      1 = digit permanently dark
//   hex        decoder data {D3,D2,D1,D0}
//   point      decoder point input
//   dec_le     decoder LE, 1 = segments off
//   an         active-low digit anodes
//   frame_done 1-cycle pulse after the last digit's slot ends
// -----------------------------------------------------------------------------
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int unsigned DIGITS    = 4,
  parameter int unsigned SCAN_W    = 17,
  parameter int unsigned BLANK_CYC = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   hexs,
  input  logic [DIGITS-1:0]     points,
  input  logic [DIGITS-1:0]     blank,
  output logic [3:0]            hex,
  output logic                  point,
  output logic                  dec_le,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done
);

  localparam int unsigned IDX_W = $clog2(DIGITS);

  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DIGITS - 1);
  localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);
  localparam logic [SCAN_W-1:0] BLANK_END = SCAN_W'(BLANK_CYC - 1);
  localparam logic [DIGITS-1:0] AN_ALL_OFF = AN_OFF[DIGITS-1:0];

  logic [SCAN_W-1:0] count_s;
  logic              wrap_s;

  scan_prescaler #(
    .SCAN_W (SCAN_W)
  ) u_prescaler (
    .clk_i   (clk),
    .rst_i   (rst),
    .count_o (count_s),
    .wrap_o  (wrap_s)
  );

  scan_state_e          state_q,     state_d;
  logic [IDX_W-1:0]     idx_q,       idx_d;
  logic [4*DIGITS-1:0]  hexs_sh_q,   hexs_sh_d;
  logic [DIGITS-1:0]    points_sh_q, points_sh_d;
  logic [DIGITS-1:0]    blank_sh_q,  blank_sh_d;

  logic [3:0]           hex_q,    hex_d;
  logic                 point_q,  point_d;
  logic                 dec_le_q, dec_le_d;
  logic [DIGITS-1:0]    an_q,     an_d;
  logic                 frame_done_q, frame_done_d;

  logic [MAX_DIGITS-1:0] an_sel_s;

  // Next-state: scan FSM, digit index, shadow capture.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    hexs_sh_d   = hexs_sh_q;
    points_sh_d = points_sh_q;
    blank_sh_d  = blank_sh_q;
    frame_done_d = 1'b0;

    if (load) begin
      hexs_sh_d   = hexs;
      points_sh_d = points;
      blank_sh_d  = blank;
    end else begin
      hexs_sh_d   = hexs_sh_q;
      points_sh_d = points_sh_q;
      blank_sh_d  = blank_sh_q;
    end

    case (state_q)
      SCAN_BLANK: begin
        if (count_s == BLANK_END) begin
          state_d = SCAN_SHOW;
        end else begin
          state_d = SCAN_BLANK;
        end
      end
      SCAN_SHOW: begin
        if (wrap_s) begin
          state_d = SCAN_BLANK;
          if (idx_q == LAST_IDX) begin
            idx_d        = '0;
            frame_done_d = 1'b1;
          end else begin
            idx_d = idx_q + IDX_ONE;
          end
        end else begin
          state_d = SCAN_SHOW;
        end
      end
      default: begin
        state_d = SCAN_BLANK;
        idx_d   = '0;
      end
    endcase
  end

  assign an_sel_s = an_select(3'(idx_d));

  // Output image computed from next-state so registered outputs align with the slot.
  always_comb begin
    hex_d   = hexs_sh_d[4*idx_d +: 4];
    point_d = points_sh_d[idx_d];
    if (state_d == SCAN_SHOW) begin
      an_d     = an_sel_s[DIGITS-1:0];
      dec_le_d = blank_sh_d[idx_d];
    end else begin
      an_d     = AN_ALL_OFF;
      dec_le_d = 1'b1;
    end
  end

  // State, shadow and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= SCAN_BLANK;
      idx_q        <= '0;
      hexs_sh_q    <= '0;
      points_sh_q  <= '0;
      blank_sh_q   <= '0;
      hex_q        <= 4'h0;
      point_q      <= 1'b0;
      dec_le_q     <= 1'b1;
      an_q         <= AN_ALL_OFF;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      hexs_sh_q    <= hexs_sh_d;
      points_sh_q  <= points_sh_d;
      blank_sh_q   <= blank_sh_d;
      hex_q        <= hex_d;
      point_q      <= point_d;
      dec_le_q     <= dec_le_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign hex        = hex_q;
  assign point      = point_q;
  assign dec_le     = dec_le_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;

endmodule
